rs_scheduler: RTL and testbench

RS_SCHEDULER -- requirements
Module: rs_scheduler

---
 rtl/tomasulo_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/rs_scheduler.sv | 98 +++++++++
 tb/tb_rs_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo-core definitions: reservation-station geometry and slot index type.
package tomasulo_pkg;
  localparam int RS_SLOTS = 8;
  localparam int IDX_W    = 3;

  typedef logic [IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N = RS_SLOTS,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  // Scan offsets from farthest to nearest so the nearest match wins; the
  // index wraps naturally because N is a power of two.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + W'(i)]) begin
        gnt_idx   = ptr + W'(i);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: lowest-free-slot dispatch allocation and
// round-robin issue selection over busy & operand-ready slots.
module rs_scheduler
  import tomasulo_pkg::*;
#(
  parameter int RS_SLOTS = tomasulo_pkg::RS_SLOTS,
  parameter int IDX_W    = tomasulo_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  output logic [IDX_W-1:0]    disp_slot,
  output logic                rs_we,
  input  logic [RS_SLOTS-1:0] slot_ready,
  input  logic                fu_ready,
  output logic                issue_valid,
  output logic [IDX_W-1:0]    issue_slot,
  output logic [RS_SLOTS-1:0] busy,
  output logic [IDX_W:0]      count,
  output logic                full,
  output logic                empty
);

  logic [RS_SLOTS-1:0] busy_q, busy_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]      count_q, count_d;

  logic [RS_SLOTS-1:0] eligible;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                grant;

  assign busy  = busy_q;
  assign count = count_q;
  assign full  = (count_q == (IDX_W+1)'(RS_SLOTS));
  assign empty = (count_q == '0);

  // Lowest free slot; defaults to 0 when nothing is free.
  always_comb begin
    disp_slot = '0;
    for (int i = RS_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) disp_slot = IDX_W'(i);
    end
  end

  assign disp_ready = !full && !flush;
  assign rs_we      = disp_valid && disp_ready;

  // Only the registered busy vector qualifies, so a slot written this cycle
  // cannot issue until the next one.
  assign eligible = busy_q & slot_ready;

  rr_arbiter #(.N(RS_SLOTS), .W(IDX_W)) u_arb (
    .req      (eligible),
    .ptr      (rr_ptr_q),
    .gnt_idx  (arb_idx),
    .gnt_valid(arb_valid)
  );

  assign issue_valid = arb_valid && !flush;
  assign issue_slot  = issue_valid ? arb_idx : '0;
  assign grant       = issue_valid && fu_ready;

  always_comb begin
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      busy_d   = '0;
      rr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Dispatch targets a free slot and grant a busy one, so they never collide.
      if (rs_we) busy_d[disp_slot] = 1'b1;
      if (grant) begin
        busy_d[issue_slot] = 1'b0;
        rr_ptr_d           = issue_slot + 1'b1;
      end
      if (rs_we && !grant)      count_d = count_q + 1'b1;
      else if (grant && !rs_we) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: slot sequences go through a scoreboard queue.
module tb_rs_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, flush, disp_valid, fu_ready;
  logic [7:0] slot_ready;
  logic       disp_ready, rs_we, issue_valid, full, empty;
  logic [2:0] disp_slot, issue_slot;
  logic [7:0] busy;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_slot(disp_slot), .rs_we(rs_we),
    .slot_ready(slot_ready), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_slot(issue_slot), .busy(busy), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    int e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: got %0h want <queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0; slot_ready = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_disp_slot", disp_slot, 0);
    chk("rst_issue_slot", issue_slot, 0);
    #10 rst_n = 1'b1;
    tick();

    // Three dispatches, nothing ready
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    disp_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("d3_we", rs_we, 1);
      chk_pop("d3_slot", disp_slot);
      tick();
    end
    disp_valid = 1'b0;
    #1;
    chk("d3_busy", busy, 8'b0000_0111);
    chk("d3_count", count, 3);
    chk("d3_issue_valid", issue_valid, 0);

    // Slot 1 ready, FU stalls 3 cycles, then grant
    slot_ready = 8'b0000_0010;
    repeat (3) begin
      #1;
      chk("hold_valid", issue_valid, 1);
      chk("hold_slot", issue_slot, 1);
      tick();
      chk("hold_busy1", busy[1], 1);
    end
    fu_ready = 1'b1;
    #1;
    chk("hold_grant_slot", issue_slot, 1);
    tick();
    fu_ready = 1'b0; slot_ready = '0;
    #1;
    chk("hold_busy_after", busy, 8'b0000_0101);
    chk("hold_count_after", count, 2);

    // Fill to 5 (slots 1,3,4), then flush with dispatch and grant pending
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(4);
    disp_valid = 1'b1;
    repeat (3) begin
      #1;
      chk_pop("f5_slot", disp_slot);
      tick();
    end
    #1;
    chk("f5_count", count, 5);
    flush = 1'b1; slot_ready = 8'hFF; fu_ready = 1'b1;
    #1;
    chk("fl_disp_ready", disp_ready, 0);
    chk("fl_rs_we", rs_we, 0);
    chk("fl_issue_valid", issue_valid, 0);
    tick();
    flush = 1'b0; disp_valid = 1'b0; slot_ready = '0; fu_ready = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_empty", empty, 1);
    chk("fl_count", count, 0);

    // Refill slots 0..3; ready 1 and 3 tells whether rr_ptr was reset to 0
    disp_valid = 1'b1;
    repeat (4) tick();
    disp_valid = 1'b0;
    slot_ready = 8'b0000_1010; fu_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(3);
    repeat (2) begin
      #1;
      chk_pop("ptr0_issue", issue_slot);
      tick();
    end
    // Pointer is 4 now: 0 then 2 drain the rest, leaving rr_ptr = 3
    slot_ready = 8'b0000_0101;
    exp_q.push_back(0); exp_q.push_back(2);
    repeat (2) begin
      #1;
      chk_pop("wrap_issue", issue_slot);
      tick();
    end
    fu_ready = 1'b0; slot_ready = '0;
    #1;
    chk("drain_empty", empty, 1);

    // Dispatch with operands ready: not issuable in the same cycle
    slot_ready = 8'hFF; disp_valid = 1'b1;
    #1;
    chk("same_cyc_we", rs_we, 1);
    chk("same_cyc_issue", issue_valid, 0);
    tick();
    slot_ready = '0;
    repeat (7) tick();
    disp_valid = 1'b0;
    #1;
    chk("full_flag", full, 1);
    chk("full_busy", busy, 8'hFF);
    chk("full_disp_ready", disp_ready, 0);
    chk("full_disp_slot", disp_slot, 0);

    // Round-robin from rr_ptr = 3 over ready {2,5}
    slot_ready = 8'b0010_0100; fu_ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(2);
    repeat (2) begin
      #1;
      chk("rr_valid", issue_valid, 1);
      chk_pop("rr_issue", issue_slot);
      tick();
    end
    #1;
    chk("rr_done_valid", issue_valid, 0);
    fu_ready = 1'b0; slot_ready = '0;

    // Refill slots 2,5 to full
    exp_q.push_back(2); exp_q.push_back(5);
    disp_valid = 1'b1;
    repeat (2) begin
      #1;
      chk_pop("refill_slot", disp_slot);
      tick();
    end
    // Full, dispatch pending, ready {1,4}: rr_ptr 3 picks 4
    slot_ready = 8'b0001_0010; fu_ready = 1'b1;
    #1;
    chk("fg_full", full, 1);
    chk("fg_disp_ready", disp_ready, 0);
    chk("fg_rs_we", rs_we, 0);
    chk("fg_issue_slot", issue_slot, 4);
    tick();
    fu_ready = 1'b0;
    #1;
    chk("fg_next_ready", disp_ready, 1);
    chk("fg_next_slot", disp_slot, 4);
    chk("fg_next_count", count, 7);

    // Simultaneous dispatch (slot 4) and grant (slot 1, wrapping from ptr 5)
    fu_ready = 1'b1;
    #1;
    chk("sim_we", rs_we, 1);
    chk("sim_issue_slot", issue_slot, 1);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("sim_count", count, 7);
    chk("sim_busy", busy, 8'b1111_1101);
    chk("sim_freed_slot", disp_slot, 1);
    // Only slot 1 claims ready, but it is free: must not issue
    slot_ready = 8'b0000_0010;
    #1;
    chk("nonbusy_ignored", issue_valid, 0);
    fu_ready = 1'b0; slot_ready = '0;

    // Knock count to 6, then async reset mid-cycle
    slot_ready = 8'b0000_0001; fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0; slot_ready = '0;
    #1;
    chk("pre_rst_count", count, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_empty", empty, 1);
    chk("async_count", count, 0);
    tick();
    rst_n = 1'b1;
    disp_valid = 1'b1;
    #1;
    chk("post_rst_slot", disp_slot, 0);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("post_rst_count", count, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
